jk_sr_ff_bank: RTL and testbench



---
 rtl/jk_sr_ff_bank_if.sv | 26 ++
 rtl/jk_sr_ff_bank.sv | 73 +++++++
 tb/tb_jk_sr_ff_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_sr_ff_bank_if.sv
// Signal bundle for jk_sr_ff_bank: configuration, per-channel stimulus and registered state.
interface jk_sr_ff_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 cfg_we;
  logic [2*WIDTH-1:0]   cfg_mode;
  logic                 en;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     err_clr;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     q_bar;
  logic [2*WIDTH-1:0]   mode;
  logic [WIDTH-1:0]     sr_err;
  logic                 err_any;

  modport master (
    output cfg_we, cfg_mode, en, a, b, err_clr,
    input  q, q_bar, mode, sr_err, err_any
  );

  modport slave (
    input  cfg_we, cfg_mode, en, a, b, err_clr,
    output q, q_bar, mode, sr_err, err_any
  );
endinterface

// File: rtl/jk_sr_ff_bank.sv
// Bank of WIDTH independent flip-flop channels, each runtime-configurable as D, T, JK or SR,
// with sticky per-channel detection of the forbidden S=R=1 input in SR mode.
module jk_sr_ff_bank #(
  parameter int unsigned WIDTH      = 8,
  parameter logic [1:0]  RESET_MODE = 2'b10
) (
  input logic            clk,
  input logic            rst,
  jk_sr_ff_bank_if.slave bus
);
  localparam logic [1:0] ModeD  = 2'b00;
  localparam logic [1:0] ModeT  = 2'b01;
  localparam logic [1:0] ModeJk = 2'b10;
  localparam logic [1:0] ModeSr = 2'b11;

  logic [WIDTH-1:0]   r_q;
  logic [2*WIDTH-1:0] r_mode;
  logic [WIDTH-1:0]   r_err;
  logic [WIDTH-1:0]   w_q_d;
  logic [WIDTH-1:0]   w_err_d;

  // Set of sr_err takes priority over err_clr, so the clear is applied first and overridden below.
  always_comb begin
    w_q_d   = r_q;
    w_err_d = r_err & ~bus.err_clr;
    if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (r_mode[2*i +: 2])
          ModeD: w_q_d[i] = bus.a[i];
          ModeT: w_q_d[i] = r_q[i] ^ bus.a[i];
          ModeJk: begin
            unique case ({bus.a[i], bus.b[i]})
              2'b10:   w_q_d[i] = 1'b1;
              2'b01:   w_q_d[i] = 1'b0;
              2'b11:   w_q_d[i] = ~r_q[i];
              default: w_q_d[i] = r_q[i];
            endcase
          end
          ModeSr: begin
            unique case ({bus.a[i], bus.b[i]})
              2'b10:   w_q_d[i] = 1'b1;
              2'b01:   w_q_d[i] = 1'b0;
              2'b11:   w_err_d[i] = 1'b1;
              default: w_q_d[i] = r_q[i];
            endcase
          end
          default: w_q_d[i] = r_q[i];
        endcase
      end
    end
  end

  // q still uses the old mode on the edge that loads a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_mode <= {WIDTH{RESET_MODE}};
      r_err  <= '0;
    end else begin
      r_q   <= w_q_d;
      r_err <= w_err_d;
      if (bus.cfg_we) begin
        r_mode <= bus.cfg_mode;
      end
    end
  end

  assign bus.q       = r_q;
  assign bus.q_bar   = ~r_q;
  assign bus.mode    = r_mode;
  assign bus.sr_err  = r_err;
  assign bus.err_any = |r_err;
endmodule

// File: tb/tb_jk_sr_ff_bank.sv
// Self-checking bench for jk_sr_ff_bank: directed table, reset corners, random vs. model,
// plus T-mode toggle runs on WIDTH=1 and WIDTH=32 builds.
module tb_jk_sr_ff_bank;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jk_sr_ff_bank_if #(.WIDTH(8))  ifc8 ();
  jk_sr_ff_bank_if #(.WIDTH(1))  ifc1 ();
  jk_sr_ff_bank_if #(.WIDTH(32)) ifc32 ();

  jk_sr_ff_bank #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(ifc8));
  jk_sr_ff_bank #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(ifc1));
  jk_sr_ff_bank #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(ifc32));

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: one integer per channel for state, mode (0=D,1=T,2=JK,3=SR) and error.
  int m_q[8];
  int m_mode[8];
  int m_err[8];

  typedef struct {
    logic        cfg_we;
    logic [15:0] cfg_mode;
    logic        en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  clr;
    logic [7:0]  exp_q;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_q[i]    = 0;
      m_mode[i] = 2;
      m_err[i]  = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 8; i++) begin
      bit ai = ifc8.a[i];
      bit bi = ifc8.b[i];
      bit set_err = 1'b0;
      if (ifc8.en) begin
        case (m_mode[i])
          0: m_q[i] = ai ? 1 : 0;
          1: if (ai) m_q[i] = 1 - m_q[i];
          2: begin
            if (ai && bi) m_q[i] = 1 - m_q[i];
            else if (ai)  m_q[i] = 1;
            else if (bi)  m_q[i] = 0;
          end
          default: begin
            if (ai && bi) set_err = 1'b1;
            else if (ai)  m_q[i] = 1;
            else if (bi)  m_q[i] = 0;
          end
        endcase
      end
      if (set_err) m_err[i] = 1;
      else if (ifc8.err_clr[i]) m_err[i] = 0;
      if (ifc8.cfg_we) m_mode[i] = int'(ifc8.cfg_mode[2*i +: 2]);
    end
  endfunction

  task automatic check_model(input string tag);
    logic [7:0]  eq;
    logic [7:0]  eqb;
    logic [7:0]  ee;
    logic [15:0] em;
    for (int i = 0; i < 8; i++) begin
      eq[i]        = (m_q[i] != 0);
      ee[i]        = (m_err[i] != 0);
      em[2*i +: 2] = 2'(m_mode[i]);
    end
    eqb = ~eq;
    check({tag, ".q"},       64'(ifc8.q),       64'(eq));
    check({tag, ".q_bar"},   64'(ifc8.q_bar),   64'(eqb));
    check({tag, ".mode"},    64'(ifc8.mode),    64'(em));
    check({tag, ".sr_err"},  64'(ifc8.sr_err),  64'(ee));
    check({tag, ".err_any"}, 64'(ifc8.err_any), 64'(|ee));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic drive8(input logic we, input logic [15:0] cm, input logic en,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] clr);
    ifc8.cfg_we   = we;
    ifc8.cfg_mode = cm;
    ifc8.en       = en;
    ifc8.a        = a;
    ifc8.b        = b;
    ifc8.err_clr  = clr;
  endtask

  initial begin
    logic        e1;
    logic        e1b;
    logic [31:0] e32;
    logic [31:0] e32b;

    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b1, 16'hAAE4, 1'b1, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 8'h0F, 8'h00, 8'h00, 8'h0D, 8'h00};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 8'h08, 8'h08, 8'h00, 8'h0D, 8'h00};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 8'h08, 8'h08, 8'h00, 8'h0C, 8'h08};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 8'h08, 8'h08, 8'h08, 8'h0C, 8'h08};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 8'h08, 8'h0C, 8'h00};

    rst = 1'b1;
    drive8(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0);
    ifc1.cfg_we = 1'b0;  ifc1.cfg_mode = '0;  ifc1.en = 1'b0;
    ifc1.a = '0;  ifc1.b = '0;  ifc1.err_clr = '0;
    ifc32.cfg_we = 1'b0; ifc32.cfg_mode = '0; ifc32.en = 1'b0;
    ifc32.a = '0; ifc32.b = '0; ifc32.err_clr = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model("por");
    rst = 1'b0;

    // Asynchronous reset between edges with q=A5; a cfg write during reset must be lost.
    drive8(1'b0, 16'h0, 1'b1, 8'hA5, 8'h5A, 8'h00);
    tick();
    check("pre_rst.q", 64'(ifc8.q), 64'h A5);
    #3 rst = 1'b1;
    drive8(1'b1, 16'h0000, 1'b1, 8'hFF, 8'hFF, 8'h00);
    #1;
    check("async_rst.q",      64'(ifc8.q),      64'h00);
    check("async_rst.q_bar",  64'(ifc8.q_bar),  64'hFF);
    check("async_rst.mode",   64'(ifc8.mode),   64'hAAAA);
    check("async_rst.sr_err", 64'(ifc8.sr_err), 64'h00);
    model_reset();
    tick();
    check("rst_cfg_lost.mode", 64'(ifc8.mode), 64'hAAAA);
    check("rst_hold.q",        64'(ifc8.q),    64'h00);
    #2 rst = 1'b0;
    drive8(1'b0, 16'h0, 1'b1, 8'hFF, 8'hFF, 8'h00);
    tick();
    check("post_rst_jk.q", 64'(ifc8.q), 64'hFF);

    // Directed table from a fresh reset.
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 13; k++) begin
      drive8(tbl[k].cfg_we, tbl[k].cfg_mode, tbl[k].en, tbl[k].a, tbl[k].b, tbl[k].clr);
      tick();
      check($sformatf("tbl%0d.q", k),       64'(ifc8.q),       64'(tbl[k].exp_q));
      check($sformatf("tbl%0d.q_bar", k),   64'(ifc8.q_bar),   64'(8'(~tbl[k].exp_q)));
      check($sformatf("tbl%0d.sr_err", k),  64'(ifc8.sr_err),  64'(tbl[k].exp_err));
      check($sformatf("tbl%0d.err_any", k), 64'(ifc8.err_any), 64'(|tbl[k].exp_err));
    end
    check_model("tbl_end");

    // Random stimulus against the model, with one mid-cycle reset.
    for (int k = 0; k < 400; k++) begin
      drive8(($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 3) != 0),
             8'($urandom), 8'($urandom), 8'($urandom & $urandom & $urandom));
      tick();
      check_model($sformatf("rnd%0d", k));
      if (k == 200) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_model("rnd_rst");
        rst = 1'b0;
      end
    end

    // T-mode toggle runs on the narrow and wide builds.
    drive8(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0);
    ifc1.cfg_we  = 1'b1; ifc1.cfg_mode  = 2'b01;          ifc1.en  = 1'b0;
    ifc32.cfg_we = 1'b1; ifc32.cfg_mode = {32{2'b01}};    ifc32.en = 1'b0;
    tick();
    ifc1.cfg_we  = 1'b0; ifc1.en  = 1'b1; ifc1.a  = 1'b1;
    ifc32.cfg_we = 1'b0; ifc32.en = 1'b1; ifc32.a = '1;
    e1  = 1'b0;
    e32 = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      e1   = ~e1;
      e32  = ~e32;
      e1b  = ~e1;
      e32b = ~e32;
      check($sformatf("w1_t%0d.q", k),      64'(ifc1.q),      64'(e1));
      check($sformatf("w1_t%0d.q_bar", k),  64'(ifc1.q_bar),  64'(e1b));
      check($sformatf("w32_t%0d.q", k),     64'(ifc32.q),     64'(e32));
      check($sformatf("w32_t%0d.q_bar", k), 64'(ifc32.q_bar), 64'(e32b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
